// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
//   PIPE_NOP_INST  : encoding of the bubble instruction (sll $0,$0,0)
//   PIPE_RESET_PC  : default PC after reset
//   fetch_state_e  : fetch FSM encoding (2 bits)
//   word_align()   : clears the byte-offset bits of an address
package pipe_pkg;

    localparam logic [31:0] PIPE_NOP_INST = 32'h0000_0000;
    localparam logic [31:0] PIPE_RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // request outstanding on the memory port
        S_HOLD = 2'd1,  // response captured while the pipe was stalled
        S_DROP = 2'd2   // stale request in flight, its data will be discarded
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry instruction hold buffer used while the fetch stage is stalled
// with a response already returned by memory.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   load         : capture data_in and mark full (wins over clear)
//   clear        : mark empty
//   data_in      : instruction from memory
//   data_out     : held instruction
//   full         : 1 = data_out holds a valid instruction
module fetch_skid_buf
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        full
);

    logic [31:0] data_q, data_d;
    logic        full_q, full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (load) begin
            data_d = data_in;
            full_d = 1'b1;
        end else if (clear) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= PIPE_NOP_INST;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data_out = data_q;
    assign full     = full_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// The PC is only advanced on a completed memory handshake; memory-latency
// cycles reach ID as invalid NOP bubbles.
// Memory handshake: imem_req is held with a stable imem_addr until a cycle in
// which imem_ready is also high; that cycle transfers imem_rdata.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   PCWrite           : 0 holds the PC (load-use stall)
//   IF2ID_write       : 0 holds the IF/ID register
//   IF2ID_flush       : 1 overwrites IF/ID with a NOP bubble
//   redirect_valid/pc : taken branch/jump target (low two bits ignored)
//   imem_req/addr     : fetch request and word-aligned address
//   imem_ready/rdata  : memory response
//   pc                : current fetch PC
//   IF2ID_inst/PC_plus4/valid : instruction delivered to ID
//   fetch_state       : FSM state, for observation
module if_fetch_unit
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PIPE_RESET_PC,
    parameter logic [31:0] NOP_INST = PIPE_NOP_INST
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         PCWrite,
    input  logic         IF2ID_write,
    input  logic         IF2ID_flush,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ready,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  pc,
    output logic [31:0]  IF2ID_inst,
    output logic [31:0]  IF2ID_PC_plus4,
    output logic         IF2ID_valid,
    output fetch_state_e fetch_state
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_q, pend_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  pc4_q, pc4_d;
    logic         valid_q, valid_d;

    logic         buf_load, buf_clear, buf_full;
    logic [31:0]  buf_data;

    // New instruction offered to IF/ID this cycle (before flush/hold priority).
    logic         if_load;
    logic [31:0]  if_new_inst;

    logic [31:0]  redir_aligned;
    logic [31:0]  pc_plus4;

    assign redir_aligned = word_align(redirect_pc);
    assign pc_plus4      = pc_q + 32'd4;

    fetch_skid_buf u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (buf_load),
        .clear    (buf_clear),
        .data_in  (imem_rdata),
        .data_out (buf_data),
        .full     (buf_full)
    );

    // Fetch FSM: next state, PC, pending target and skid-buffer control.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        buf_load    = 1'b0;
        buf_clear   = 1'b0;
        if_load     = 1'b0;
        if_new_inst = imem_rdata;

        case (state_q)
            S_REQ: begin
                if (imem_ready) begin
                    if (redirect_valid) begin
                        // Wrong-path response: drop it and restart at target.
                        pc_d = redir_aligned;
                    end else if (PCWrite && IF2ID_write) begin
                        if_load     = 1'b1;
                        if_new_inst = imem_rdata;
                        pc_d        = pc_plus4;
                    end else begin
                        // Stalled: park the response, stop requesting.
                        buf_load = 1'b1;
                        state_d  = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    // The request must complete at its old address first.
                    pend_d  = redir_aligned;
                    state_d = S_DROP;
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    buf_clear = 1'b1;
                    pc_d      = redir_aligned;
                    state_d   = S_REQ;
                end else if (PCWrite && IF2ID_write && buf_full) begin
                    if_load     = 1'b1;
                    if_new_inst = buf_data;
                    buf_clear   = 1'b1;
                    pc_d        = pc_plus4;
                    state_d     = S_REQ;
                end
            end

            S_DROP: begin
                if (redirect_valid) begin
                    pend_d = redir_aligned;  // latest redirect wins
                end
                if (imem_ready) begin
                    pc_d    = redirect_valid ? redir_aligned : pend_q;
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // IF/ID register: flush beats hold beats load/bubble.
    always_comb begin
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (IF2ID_flush) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else if (!IF2ID_write) begin
            inst_d  = inst_q;
        end else if (if_load) begin
            inst_d  = if_new_inst;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end else begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            pend_q  <= 32'd0;
            inst_q  <= NOP_INST;
            pc4_q   <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req       = ((state_q == S_REQ) || (state_q == S_DROP)) && !reset;
    assign imem_addr      = word_align(pc_q);
    assign pc             = pc_q;
    assign IF2ID_inst     = inst_q;
    assign IF2ID_PC_plus4 = pc4_q;
    assign IF2ID_valid    = valid_q;
    assign fetch_state    = state_q;

endmodule
